// File: rtl/controlador_busca.sv
// controlador_busca: instruction-fetch sequencer owning the PC, with a one-word valid/ready output buffer
module controlador_busca #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] instrucao_mem,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              wrapped,
  output logic [15:0]       fetch_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALTED = 2'd2} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_out_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_valid_q;
  logic              halted_q;
  logic              wrapped_q;
  logic [15:0]       fetch_count_q;
  logic              transfer;
  logic              stall;
  assign transfer    = inst_valid_q && inst_ready;
  assign stall       = inst_valid_q && !inst_ready;
  assign endereco    = pc_q;
  assign inst_out    = inst_out_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign halted      = halted_q;
  assign wrapped     = wrapped_q;
  assign fetch_count = fetch_count_q;
  // fetch FSM: redirect beats stall beats capture; the memory word was read from pc at the previous falling edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= START_ADDR;
      inst_out_q    <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      wrapped_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= FETCH;
        FETCH: begin
          if (redirect) begin
            pc_q         <= redirect_addr;
            inst_valid_q <= 1'b0;
          end else if (!stall) begin
            inst_out_q   <= instrucao_mem;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
            if (fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
            if (instrucao_mem == HALT_OPCODE) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
              if (pc_q == '1) wrapped_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (start) begin
            pc_q         <= START_ADDR;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            state_q      <= FETCH;
          end else if (transfer) inst_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_controlador_busca.sv
// tb_controlador_busca: directed plus random stimulus against a behavioural fetch model
module tb_controlador_busca;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] endereco;
  logic [7:0] instrucao_mem;
  logic [7:0] inst_out;
  logic [7:0] inst_pc;
  logic       inst_valid;
  logic       inst_ready = 1'b1;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       halted;
  logic       wrapped;
  logic [15:0] fetch_count;
  logic [7:0] mem [256];
  int n_assert = 0;
  int n_fail = 0;
  bit m_running, m_halted, m_valid, m_wrapped;
  int m_pc, m_out, m_ipc, m_count;

  controlador_busca dut (
    .clock(clock), .reset(reset), .start(start), .endereco(endereco),
    .instrucao_mem(instrucao_mem), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_addr(redirect_addr), .halted(halted), .wrapped(wrapped),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;
  always @(negedge clock) instrucao_mem = mem[endereco];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int w;
    if (reset) begin
      m_running = 0; m_halted = 0; m_valid = 0; m_wrapped = 0;
      m_pc = 0; m_out = 0; m_ipc = 0; m_count = 0;
    end else if (!m_running && !m_halted) begin
      if (start) m_running = 1;
    end else if (m_running) begin
      if (redirect) begin
        m_pc = redirect_addr;
        m_valid = 0;
      end else if (!(m_valid && !inst_ready)) begin
        w = mem[m_pc];
        m_out = w;
        m_ipc = m_pc;
        m_valid = 1;
        m_count = (m_count < 65535) ? m_count + 1 : 65535;
        if (w == 255) begin
          m_running = 0;
          m_halted = 1;
        end else begin
          if (m_pc == 255) m_wrapped = 1;
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else begin
      if (start) begin
        m_pc = 0; m_valid = 0; m_halted = 0; m_running = 1;
      end else if (m_valid && inst_ready) m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("endereco", endereco, m_pc);
    chk("inst_valid", inst_valid, m_valid);
    chk("inst_out", inst_out, m_out);
    chk("inst_pc", inst_pc, m_ipc);
    chk("halted", halted, m_halted);
    chk("wrapped", wrapped, m_wrapped);
    chk("fetch_count", fetch_count, m_count);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[5] = 8'hFF; mem[200] = 8'hFF;
    step(); step();
    chk("reset_valid", inst_valid, 1'b0);
    chk("reset_addr", endereco, 8'h00);
    reset = 1'b0;
    step();
    chk("idle_no_capture", inst_valid, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk("first_edge_not_valid", inst_valid, 1'b0);
    step();
    chk("w0", {inst_valid, inst_pc, inst_out}, {1'b1, 8'h00, 8'h11});
    step(); chk("w1", {inst_pc, inst_out}, {8'h01, 8'h22});
    step(); chk("w2", {inst_pc, inst_out}, {8'h02, 8'h33});
    step(); chk("w3", {inst_pc, inst_out}, {8'h03, 8'h44});
    chk("count4", fetch_count, 16'd4);
    step(); step();
    chk("halt", {halted, inst_out, inst_pc, endereco}, {1'b1, 8'hFF, 8'h05, 8'h05});
    step(); chk("halt_consumed", inst_valid, 1'b0);
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("restart", {halted, endereco, inst_valid}, {1'b0, 8'h00, 1'b0});
    step(); step();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", {inst_valid, inst_pc, inst_out, endereco}, {1'b1, 8'h01, 8'h22, 8'h02});
    end
    inst_ready = 1'b1;
    step(); chk("resume", {inst_pc, inst_out}, {8'h02, 8'h33});
    step(); step(); step();
    chk("halt2", halted, 1'b1);
    step();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("at22", inst_out, 8'h22);
    inst_ready = 1'b0; step();
    redirect = 1'b1; redirect_addr = 8'h80; step();
    chk("redirect_flush", {inst_valid, endereco}, {1'b0, 8'h80});
    redirect = 1'b0; inst_ready = 1'b1; step();
    chk("redirect_word", {inst_pc, inst_out}, {8'h80, mem[128]});
    redirect = 1'b1; redirect_addr = 8'hFE; step(); redirect = 1'b0;
    step(); chk("wrap_254", {inst_pc, wrapped}, {8'hFE, 1'b0});
    step(); chk("wrap_255", {inst_pc, wrapped}, {8'hFF, 1'b1});
    step(); chk("wrap_0", {inst_pc, wrapped}, {8'h00, 1'b1});
    step(); chk("wrap_1", {inst_pc, wrapped}, {8'h01, 1'b1});
    for (int i = 0; i < 500; i++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_addr = 8'($urandom_range(0, 255));
      start = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    reset = 1'b0; start = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("pre_reset_valid", inst_valid, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_reset", {inst_valid, halted, wrapped, fetch_count, endereco, inst_out, inst_pc},
        {1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 8'h00});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle", {inst_valid, fetch_count}, {1'b0, 16'd0});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
